// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector: gradient width,
// pipeline depth, saturation limit and kernel weights.
package sobel_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int GRAD_EXTRA = 3;
    localparam int GRAD_W     = DEF_DATA_W + GRAD_EXTRA;
    localparam int PIPE_LAT   = 3;
    localparam int SAT_MAX    = (1 << DEF_DATA_W) - 1;

    // Sobel weights: outer taps of a kernel column/row, and the centre tap.
    localparam int K_EDGE = 1;
    localparam int K_MID  = 2;

    function automatic int grad_width(input int data_w);
        return data_w + GRAD_EXTRA;
    endfunction

    function automatic int sat_max(input int data_w);
        return (1 << data_w) - 1;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of storage, addressed by column. A read in the same cycle
// as a write to that column returns the previously stored pixel.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 640,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, gradient magnitude or
// thresholded edge map out, three register stages after the window.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pix,
    input  logic              mode,
    input  logic [DATA_W-1:0] thresh,
    output logic              out_valid,
    output logic              out_eof,
    output logic [DATA_W-1:0] out_pix
);

    localparam int G_W = grad_width(DATA_W);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [G_W-1:0] SAT_LIM = G_W'(sat_max(DATA_W));
    localparam logic signed [G_W-1:0] KE = G_W'(K_EDGE);
    localparam logic signed [G_W-1:0] KM = G_W'(K_MID);

    logic [CW-1:0] col, cur_col, next_col;
    logic [RW-1:0] row, cur_row, next_row;
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic [DATA_W-1:0] win [3][3];
    logic signed [G_W-1:0] px [3][3];
    logic signed [G_W-1:0] gx_c, gy_c, gx, gy;
    logic [G_W-1:0] ax_c, ay_c, ax, ay, mag_c;
    logic [DATA_W-1:0] sat_c, pix_c;
    logic v0, v1, v2, eof0, eof1, eof2;

    // A start-of-frame pixel is always (0,0), regardless of where the counters are.
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        next_col = cur_col + CW'(1);
        next_row = cur_row;
        if (cur_col == COL_LAST) begin
            next_col = '0;
            next_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .we      (in_valid),
        .addr    (cur_col),
        .wr_data (in_pix),
        .rd_data (lb0_q)
    );

    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .we      (in_valid),
        .addr    (cur_col),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    // Window rows are top (two lines up) to bottom (current line).
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_q;
            win[1][2] <= lb0_q;
            win[2][2] <= in_pix;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px[r][c] = signed'(G_W'(win[r][c]));
            end
        end
        gx_c = (KE * px[0][2] + KM * px[1][2] + KE * px[2][2])
             - (KE * px[0][0] + KM * px[1][0] + KE * px[2][0]);
        gy_c = (KE * px[2][0] + KM * px[2][1] + KE * px[2][2])
             - (KE * px[0][0] + KM * px[0][1] + KE * px[0][2]);
        ax_c = gx[G_W-1] ? -gx : gx;
        ay_c = gy[G_W-1] ? -gy : gy;
        mag_c = ax + ay;
        sat_c = (mag_c > SAT_LIM) ? '1 : mag_c[DATA_W-1:0];
        pix_c = mode ? ((sat_c > thresh) ? '1 : '0) : sat_c;
    end

    always_ff @(posedge clk) begin
        gx <= gx_c;
        gy <= gy_c;
        ax <= ax_c;
        ay <= ay_c;
    end

    // Qualifiers travel alongside the data; a stalled input cycle injects a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            eof0      <= 1'b0;
            eof1      <= 1'b0;
            eof2      <= 1'b0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_pix   <= '0;
        end else begin
            v0        <= in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            eof0      <= in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            v1        <= v0;
            eof1      <= eof0;
            v2        <= v1;
            eof2      <= eof1;
            out_valid <= v2;
            out_eof   <= v2 && eof2;
            out_pix   <= pix_c;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: image-array reference model with a
// timed expectation queue, directed frames plus randomized frames and gaps.
module tb_sobel_stream;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int LAT    = 3;
    localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_pix;
    logic              mode;
    logic [DATA_W-1:0] thresh;
    logic              out_valid;
    logic              out_eof;
    logic [DATA_W-1:0] out_pix;

    always #5 clk = ~clk;

    sobel_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
        .mode      (mode),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_eof   (out_eof),
        .out_pix   (out_pix)
    );

    typedef struct {
        int due;
        int pix;
        bit eof;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   checking = 1'b0;
    exp_t exp_q[$];
    int   got_pix[$];
    bit   got_eof[$];
    int   img [IMG_H][IMG_W];
    int   m_col = 0;
    int   m_row = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int sobel_ref(input int r, input int c, input bit md, input int thr);
        int lu, cu, ru, lc, rc, lb, cb, rb, gxv, gyv, mag, sat;
        lu = img[r-2][c-2]; cu = img[r-2][c-1]; ru = img[r-2][c];
        lc = img[r-1][c-2];                     rc = img[r-1][c];
        lb = img[r][c-2];   cb = img[r][c-1];   rb = img[r][c];
        gxv = (ru + 2 * rc + rb) - (lu + 2 * lc + lb);
        gyv = (lb + 2 * cb + rb) - (lu + 2 * cu + ru);
        mag = (gxv < 0 ? -gxv : gxv) + (gyv < 0 ? -gyv : gyv);
        sat = (mag > 255) ? 255 : mag;
        if (md) return (sat > thr) ? 255 : 0;
        return sat;
    endfunction

    // Reference model: place each accepted pixel in an image array and schedule its output.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b1) begin
                exp_q.delete();
                m_col = 0;
                m_row = 0;
            end else if (in_valid === 1'b1) begin
                if (in_sof) begin
                    m_col = 0;
                    m_row = 0;
                end
                img[m_row][m_col] = int'(in_pix);
                if (m_row >= 2 && m_col >= 2) begin
                    exp_q.push_back('{due: cyc + LAT,
                                      pix: sobel_ref(m_row, m_col, mode, int'(thresh)),
                                      eof: (m_row == IMG_H - 1 && m_col == IMG_W - 1)});
                end
                m_col++;
                if (m_col == IMG_W) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
                end
            end
        end
    end

    // Every cycle: an output is present exactly when one is due, with the right value.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                if (out_valid === 1'b1) begin
                    got_pix.push_back(int'(out_pix));
                    got_eof.push_back(out_eof);
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    check_output("out_valid_due", 32'(out_valid), 1);
                    check_output("out_pix", 32'(out_pix), exp_q[0].pix);
                    check_output("out_eof", 32'(out_eof), 32'(exp_q[0].eof));
                    void'(exp_q.pop_front());
                end else begin
                    check_output("out_valid_idle", 32'(out_valid), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive(input bit v, input bit s, input int p);
        in_valid = v;
        in_sof   = s;
        in_pix   = p[7:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    function automatic int pattern(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : 200;
            2:       return 10 * c;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // gap: 0 none, 1 idle every third cycle, 2 random idles (with stray in_sof).
    task automatic apply_stimulus(input int kind, input int gap, input int stop_at);
        int k;
        k = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r * IMG_W + c == stop_at) return;
                if (gap == 1 && (k % 3) == 2) begin
                    drive(1'b0, 1'b0, 0);
                    k++;
                end
                while (gap == 2 && $urandom_range(0, 3) == 0) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
                end
                drive(1'b1, (r == 0 && c == 0), pattern(kind, r, c));
                k++;
            end
        end
    endtask

    task automatic run_frame(input int kind, input int gap, input bit md, input int thr);
        mode   = md;
        thresh = thr[7:0];
        got_pix.delete();
        got_eof.delete();
        apply_stimulus(kind, gap, -1);
        idle(6);
    endtask

    function automatic int count_eof();
        int n;
        n = 0;
        foreach (got_eof[i]) if (got_eof[i]) n++;
        return n;
    endfunction

    function automatic int count_not(input int v);
        int n;
        n = 0;
        foreach (got_pix[i]) if (got_pix[i] != v) n++;
        return n;
    endfunction

    initial begin
        int bad;
        $display("[TB] sobel_stream bench start");
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; mode = 1'b0; thresh = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_output("reset_out_valid", 32'(out_valid), 0);
        check_output("reset_out_eof", 32'(out_eof), 0);
        check_output("reset_out_pix", 32'(out_pix), 0);
        checking = 1'b1;
        idle(2);

        run_frame(0, 0, 1'b0, 0);
        check_output("flat_count", got_pix.size(), N_OUT);
        check_output("flat_nonzero", count_not(0), 0);
        check_output("flat_eof_count", count_eof(), 1);
        if (got_eof.size() == N_OUT) check_output("flat_eof_last", 32'(got_eof[N_OUT-1]), 1);

        run_frame(1, 0, 1'b0, 0);
        check_output("step_count", got_pix.size(), N_OUT);
        bad = 0;
        foreach (got_pix[i]) begin
            int cc;
            cc = (i % (IMG_W - 2)) + 1;
            if (got_pix[i] != ((cc == 3 || cc == 4) ? 255 : 0)) bad++;
        end
        check_output("step_pattern", bad, 0);

        run_frame(2, 0, 1'b0, 0);
        check_output("ramp_count", got_pix.size(), N_OUT);
        check_output("ramp_not80", count_not(80), 0);
        run_frame(2, 0, 1'b1, 50);
        check_output("ramp_thr50", count_not(255), 0);
        run_frame(2, 0, 1'b1, 80);
        check_output("ramp_thr80", count_not(0), 0);

        run_frame(2, 1, 1'b0, 0);
        check_output("gap_count", got_pix.size(), N_OUT);
        check_output("gap_not80", count_not(80), 0);
        check_output("gap_eof_count", count_eof(), 1);

        mode = 1'b0;
        apply_stimulus(2, 0, 3 * IMG_W + 3);
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        got_pix.delete();
        got_eof.delete();
        idle(10);
        check_output("rst_no_output", got_pix.size(), 0);
        run_frame(2, 0, 1'b0, 0);
        check_output("post_rst_count", got_pix.size(), N_OUT);
        check_output("post_rst_not80", count_not(80), 0);

        got_pix.delete();
        got_eof.delete();
        apply_stimulus(3, 0, 2 * IMG_W + 5);
        apply_stimulus(2, 0, -1);
        idle(6);
        check_output("sof_mid_count", got_pix.size(), 3 + N_OUT);
        check_output("sof_mid_eof_count", count_eof(), 1);
        if (got_eof.size() > 0) check_output("sof_mid_eof_last", 32'(got_eof[got_eof.size()-1]), 1);

        for (int f = 0; f < 6; f++) begin
            run_frame(3, 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            check_output("rand_count", got_pix.size(), N_OUT);
        end

        check_output("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
